// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues word requests to a variable-latency
// instruction memory and buffers in-order responses for decode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        StallD,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [TW-1:0] TAG_LAST = TW'(MAX_OUTSTANDING - 1);

  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_redir_pc;
  logic          r_redir_pend;
  logic [OW-1:0] r_out;
  logic [OW-1:0] r_discard;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [TW-1:0] r_tag_wp;
  logic [TW-1:0] r_tag_rp;
  logic [31:0]   r_fifo_data [FIFO_DEPTH];
  logic [31:0]   r_fifo_pc   [FIFO_DEPTH];
  logic [31:0]   r_tag       [MAX_OUTSTANDING];

  logic          w_gnt;
  logic          w_hold;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic          w_tag_push;
  logic          w_credit;
  logic [OW-1:0] w_out_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [31:0]   w_target;

  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    return (p == TAG_LAST) ? {TW{1'b0}} : p + TW'(1);
  endfunction

  assign imem_req    = (r_state == S_REQ);
  assign imem_addr   = r_fetch_pc;
  assign instr_valid = (r_count != {CW{1'b0}});
  assign instr       = r_fifo_data[r_rp];
  assign instr_pc    = r_fifo_pc[r_rp];

  // Handshake decode; credit is judged on post-edge occupancy so imem_req never depends on imem_gnt.
  always_comb begin
    w_target   = redirect_pc & 32'hFFFF_FFFC;
    w_gnt      = (r_state == S_REQ) && imem_gnt;
    w_hold     = (r_state == S_REQ) && !imem_gnt;
    w_drop     = imem_rvalid && (r_discard != {OW{1'b0}});
    w_push     = imem_rvalid && !redirect && (r_discard == {OW{1'b0}});
    w_pop      = instr_valid && !StallD && !redirect;
    w_tag_push = w_gnt && !redirect && !r_redir_pend;
    w_out_nxt  = r_out + OW'(w_gnt) - OW'(imem_rvalid);
    if (redirect) begin
      w_cnt_nxt = {CW{1'b0}};
    end else begin
      w_cnt_nxt = r_count + CW'(w_push) - CW'(w_pop);
    end
    w_credit   = ((32'(w_out_nxt) + 32'(w_cnt_nxt)) < 32'(FIFO_DEPTH)) &&
                 (32'(w_out_nxt) < 32'(MAX_OUTSTANDING));
  end

  // Request FSM next state: a pending request is held until granted.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: w_state_nxt = w_credit ? S_REQ : S_IDLE;
      S_REQ: begin
        if (imem_gnt) begin
          w_state_nxt = w_credit ? S_REQ : S_IDLE;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Fetch PC, outstanding/discard counters; a redirect during an ungranted request is parked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc   <= RESET_PC;
      r_redir_pc   <= RESET_PC;
      r_redir_pend <= 1'b0;
      r_out        <= {OW{1'b0}};
      r_discard    <= {OW{1'b0}};
    end else begin
      r_out <= w_out_nxt;
      if (redirect) begin
        r_discard <= w_out_nxt;
        if (w_hold) begin
          r_redir_pend <= 1'b1;
          r_redir_pc   <= w_target;
        end else begin
          r_redir_pend <= 1'b0;
          r_fetch_pc   <= w_target;
        end
      end else begin
        r_discard <= r_discard - OW'(w_drop) + OW'(w_gnt && r_redir_pend);
        if (w_gnt) begin
          r_redir_pend <= 1'b0;
          r_fetch_pc   <= r_redir_pend ? r_redir_pc : r_fetch_pc + 32'd4;
        end
      end
    end
  end

  // PC tag queue: one entry per live (non-discarded) grant, consumed by its response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) r_tag[i] <= 32'h0;
      r_tag_wp <= {TW{1'b0}};
      r_tag_rp <= {TW{1'b0}};
    end else if (redirect) begin
      r_tag_wp <= {TW{1'b0}};
      r_tag_rp <= {TW{1'b0}};
    end else begin
      if (w_tag_push) begin
        r_tag[r_tag_wp] <= r_fetch_pc;
        r_tag_wp        <= tag_inc(r_tag_wp);
      end
      if (w_push) r_tag_rp <= tag_inc(r_tag_rp);
    end
  end

  // Instruction FIFO; credit accounting guarantees a push never finds it full without a pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_data[i] <= 32'h0;
        r_fifo_pc[i]   <= 32'h0;
      end
      r_wp    <= {PW{1'b0}};
      r_rp    <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
    end else if (redirect) begin
      r_wp    <= {PW{1'b0}};
      r_rp    <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_fifo_data[r_wp] <= imem_rdata;
        r_fifo_pc[r_wp]   <= r_tag[r_tag_rp];
        r_wp              <= r_wp + PW'(1);
      end
      if (w_pop) r_rp <= r_rp + PW'(1);
      r_count <= w_cnt_nxt;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order memory model
// returning ~address as instruction data.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        StallD;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        gnt_en;
  logic        resp_en;
  logic [31:0] mem_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  instr_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .StallD(StallD), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata)
  );

  always #5 clk = ~clk;
  assign imem_gnt = gnt_en;

  // Memory: records grants, answers in order one cycle later while resp_en is set.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q.delete();
      imem_rvalid <= 1'b0;
      imem_rdata  <= 32'h0;
    end else begin
      if (imem_rvalid) void'(mem_q.pop_front());
      if (imem_req && imem_gnt) mem_q.push_back(imem_addr);
      if (resp_en && mem_q.size() > 0) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= ~mem_q[0];
      end else begin
        imem_rvalid <= 1'b0;
        imem_rdata  <= 32'h0;
      end
    end
  end

  // FIFO occupancy must never exceed its depth.
  always @(negedge clk) begin
    if (!reset) begin
      assert (int'(dut.r_count) <= 2) else begin
        n_fail++;
        $error("FAIL fifo_overflow: observed %0d expected <= 2", dut.r_count);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    check({tag, "_pc"}, instr_pc, pc);
    check({tag, "_instr"}, instr, ~pc);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; StallD = 1'b0;
    gnt_en = 1'b1; resp_en = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; StallD = 1'b0;
    gnt_en = 1'b1; resp_en = 1'b1;
    #1;
    // Reset values
    do_reset();
    reset = 1'b1;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc", instr_pc, 32'h0);

    // Free-running fetch
    do_reset();
    step(1); check("run_req1", {31'd0, imem_req}, 32'd1); check("run_addr1", imem_addr, 32'h0);
    step(1); check("run_addr2", imem_addr, 32'h4); check("run_valid2", {31'd0, instr_valid}, 32'd0);
    step(1); check_head("run_e3", 32'h0); check("run_req3", {31'd0, imem_req}, 32'd0);
    step(1); check_head("run_e4", 32'h4); check("run_addr4", imem_addr, 32'h8);
    step(1); check("run_valid5", {31'd0, instr_valid}, 32'd0); check("run_addr5", imem_addr, 32'hC);
    step(1); check_head("run_e6", 32'h8);

    // Decode stall: two entries buffered, requests stop, head stable
    do_reset();
    StallD = 1'b1;
    step(3);
    for (int i = 4; i <= 10; i++) begin
      step(1);
      check("stall_req", {31'd0, imem_req}, 32'd0);
      check_head("stall_head", 32'h0);
    end
    StallD = 1'b0;
    step(1); check_head("unstall_f1", 32'h4); check("unstall_addr1", imem_addr, 32'h8);
    step(1); check("unstall_valid2", {31'd0, instr_valid}, 32'd0); check("unstall_addr2", imem_addr, 32'hC);
    step(1); check_head("unstall_f3", 32'h8);

    // Grant withheld: request held stable
    do_reset();
    gnt_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h10;
    step(1); redirect = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("hold_req", {31'd0, imem_req}, 32'd1);
      check("hold_addr", imem_addr, 32'h10);
    end
    gnt_en = 1'b1;
    step(1); check("hold_addr_next", imem_addr, 32'h14);
    step(1); check_head("hold_head", 32'h10);

    // Redirect with two outstanding responses
    do_reset();
    resp_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h20;
    step(1); redirect = 1'b0; check("two_addr1", imem_addr, 32'h20);
    step(1); check("two_addr2", imem_addr, 32'h24);
    step(1); check("two_req3", {31'd0, imem_req}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h103; resp_en = 1'b1;
    step(1); redirect = 1'b0;
    check("two_redir_addr", imem_addr, 32'h100);
    check("two_redir_valid", {31'd0, instr_valid}, 32'd0);
    step(1); check("two_drop1_valid", {31'd0, instr_valid}, 32'd0); check("two_req5", {31'd0, imem_req}, 32'd1);
    step(1); check("two_drop2_valid", {31'd0, instr_valid}, 32'd0); check("two_addr6", imem_addr, 32'h104);
    step(1); check_head("two_target", 32'h100);

    // Redirect coinciding with rvalid and a pop
    do_reset();
    step(3); check_head("rp_pre", 32'h0);
    redirect = 1'b1; redirect_pc = 32'h200;
    step(1); redirect = 1'b0;
    check("rp_valid", {31'd0, instr_valid}, 32'd0);
    check("rp_addr", imem_addr, 32'h200);
    step(1); check("rp_valid5", {31'd0, instr_valid}, 32'd0);
    step(1); check_head("rp_target", 32'h200);

    // Redirect while a request waits for grant
    do_reset();
    gnt_en = 1'b0;
    step(1);
    redirect = 1'b1; redirect_pc = 32'h300;
    step(1); redirect = 1'b0;
    check("park_addr", imem_addr, 32'h0); check("park_req", {31'd0, imem_req}, 32'd1);
    gnt_en = 1'b1;
    step(1); check("park_addr_new", imem_addr, 32'h300);
    step(1); check("park_valid", {31'd0, instr_valid}, 32'd0);
    step(1); check_head("park_head", 32'h300);

    // PC wrap, low target bits ignored
    do_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    step(1); redirect = 1'b0; check("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
    step(1); check("wrap_addr2", imem_addr, 32'h0);
    step(1); check_head("wrap_head", 32'hFFFF_FFFC);

    // Asynchronous reset mid-transaction
    do_reset();
    StallD = 1'b1; step(4);
    StallD = 1'b0; step(1);
    StallD = 1'b1; step(1);
    check_head("ar_pre", 32'h4);
    #2 reset = 1'b1;
    #1;
    check("ar_req", {31'd0, imem_req}, 32'd0);
    check("ar_addr", imem_addr, 32'h0);
    check("ar_valid", {31'd0, instr_valid}, 32'd0);
    check("ar_instr", instr, 32'h0);
    check("ar_pc", instr_pc, 32'h0);
    step(1); StallD = 1'b0; reset = 1'b0;
    step(1); check("ar_first_req", {31'd0, imem_req}, 32'd1); check("ar_first_addr", imem_addr, 32'h0);
    step(2); check_head("ar_head", 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
